// File: rtl/mem_copy.sv
// mem_copy: word-wise memory copy/fill engine with one-word read buffer,
// misalignment rejection, abort, and async active-low reset.
module mem_copy #(
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      fill_i,
    input  logic             abort_i,
    output logic             we_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      data_o,
    input  logic [31:0]      data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] count_o
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3;
    logic [1:0]       state;
    logic [31:0]      src, dst, fill, word_q;
    logic [LEN_W-1:0] rem;
    logic             mode, misaligned;
    // src alignment only matters when we actually read from it
    assign misaligned = (!mode_i && src_i[1:0] != 2'b00) || dst_i[1:0] != 2'b00;
    always_comb begin
        we_o   = state == WR;
        addr_o = state == RD ? src : state == WR ? dst : '0;
        data_o = state == WR ? (mode ? fill : word_q) : '0;
        busy_o = state != IDLE;
        done_o = state == DONE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            fill    <= '0;
            word_q  <= '0;
            rem     <= '0;
            mode    <= 1'b0;
            err_o   <= 1'b0;
            count_o <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    src     <= src_i;
                    dst     <= dst_i;
                    fill    <= fill_i;
                    rem     <= len_i;
                    mode    <= mode_i;
                    count_o <= '0;
                    err_o   <= misaligned;
                    state   <= (misaligned || len_i == '0) ? DONE : mode_i ? WR : RD;
                end
                RD: begin
                    word_q <= data_i;
                    state  <= abort_i ? DONE : WR;
                end
                WR: begin
                    src     <= src + 32'd4;
                    dst     <= dst + 32'd4;
                    count_o <= count_o + LEN_W'(1);
                    rem     <= rem - LEN_W'(1);
                    state   <= (abort_i || rem == LEN_W'(1)) ? DONE : mode ? WR : RD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy.sv
// tb_mem_copy: randomized self-checking bench for mem_copy against a
// sequential word-copy reference model over a 1024-word memory.
module tb_mem_copy;
    logic        clk = 1'b0, rst = 1'b0;
    logic        start_i = 1'b0, mode_i = 1'b0, abort_i = 1'b0;
    logic [31:0] src_i = '0, dst_i = '0, fill_i = '0;
    logic [12:0] len_i = '0;
    logic        we_o, busy_o, done_o, err_o;
    logic [31:0] addr_o, data_o, data_i;
    logic [12:0] count_o;
    logic [31:0] mem [1024];
    logic [31:0] wlog_a[$], wlog_d[$];
    int errors = 0, checks = 0;

    mem_copy #(.LEN_W(13)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .src_i(src_i),
        .dst_i(dst_i), .len_i(len_i), .fill_i(fill_i), .abort_i(abort_i),
        .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o)
    );

    always #5 clk = ~clk;
    assign data_i = mem[addr_o[11:2]];
    always @(posedge clk) begin
        if (we_o) begin
            mem[addr_o[11:2]] <= data_o;
            wlog_a.push_back(addr_o);
            wlog_d.push_back(data_o);
        end
    end

    // abort_at / restart_at are 1-based indices of cycles spent in RD/WR (0 = never)
    task automatic run_transfer(input string name, input logic m, input logic [31:0] s,
                                input logic [31:0] d, input int n, input logic [31:0] f,
                                input int abort_at, input int restart_at);
        logic [31:0] snap [1024];
        logic [31:0] exp_a[$], exp_d[$];
        logic [31:0] a, v, sa;
        logic bad;
        int full_act, exp_act, exp_words, act, cyc, busy_low;
        bad = (!m && s[1:0] != 2'b00) || d[1:0] != 2'b00;
        full_act = (bad || n == 0) ? 0 : (m ? n : 2 * n);
        exp_act = (abort_at > 0 && abort_at < full_act) ? abort_at : full_act;
        exp_words = m ? exp_act : exp_act / 2;
        snap = mem;
        for (int i = 0; i < exp_words; i++) begin
            a = d + 32'(4 * i);
            sa = s + 32'(4 * i);
            v = m ? f : snap[sa[11:2]];
            snap[a[11:2]] = v;
            exp_a.push_back(a);
            exp_d.push_back(v);
        end
        @(negedge clk);
        mode_i = m; src_i = s; dst_i = d; len_i = 13'(n); fill_i = f; start_i = 1'b1;
        wlog_a.delete();
        wlog_d.delete();
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (err_o !== bad) begin
            errors++;
            $display("FAIL %s err_at_accept: got %b want %b", name, err_o, bad);
        end
        checks++;
        if (count_o !== 13'd0) begin
            errors++;
            $display("FAIL %s count_cleared: got %0d want 0", name, count_o);
        end
        act = 0; cyc = 0; busy_low = 0;
        while (!done_o && cyc < 10000) begin
            act++;
            if (!busy_o) busy_low++;
            abort_i = (abort_at == act);
            if (restart_at == act) begin
                start_i = 1'b1; mode_i = ~m; dst_i = d + 32'h40; src_i = s + 32'h80; len_i = 13'd1;
            end
            @(negedge clk);
            start_i = 1'b0;
            abort_i = 1'b0;
            cyc++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done_o=%b after %0d cycles", name, done_o, cyc);
        end
        checks++;
        if (act != exp_act || busy_low != 0) begin
            errors++;
            $display("FAIL %s active_cycles: got %0d (busy low %0d) want %0d", name, act, busy_low, exp_act);
        end
        checks++;
        if (wlog_a.size() != exp_words) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, wlog_a.size(), exp_words);
        end
        for (int i = 0; i < exp_words && i < wlog_a.size(); i++) begin
            checks++;
            if (wlog_a[i] !== exp_a[i] || wlog_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL %s write%0d: got %h<=%h want %h<=%h", name, i, wlog_a[i], wlog_d[i], exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (count_o !== 13'(exp_words) || err_o !== bad || busy_o !== 1'b1 || we_o !== 1'b0 || addr_o !== '0 || data_o !== '0) begin
            errors++;
            $display("FAIL %s done_state: count=%0d err=%b busy=%b we=%b addr=%h data=%h want count=%0d err=%b busy=1 zeros",
                     name, count_o, err_o, busy_o, we_o, addr_o, data_o, exp_words, bad);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 13'(exp_words) || err_o !== bad) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b count=%0d err=%b want 0 0 %0d %b",
                     name, done_o, busy_o, count_o, err_o, exp_words, bad);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({we_o, busy_o, done_o, err_o} !== 4'b0 || addr_o !== '0 || data_o !== '0 || count_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b busy=%b done=%b err=%b addr=%h data=%h count=%0d want all 0",
                     we_o, busy_o, done_o, err_o, addr_o, data_o, count_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || wlog_a.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b writes=%0d want 0 0", busy_o, wlog_a.size());
        end
    endtask

    task automatic test_copy();
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003;
        run_transfer("copy3", 1'b0, 32'h0, 32'h100, 3, 32'h0, 0, 0);
        run_transfer("overlap_up", 1'b0, 32'h300, 32'h304, 6, 32'h0, 0, 0);
        run_transfer("overlap_down", 1'b0, 32'h408, 32'h400, 5, 32'h0, 0, 0);
    endtask

    task automatic test_fill();
        run_transfer("fill4", 1'b1, 32'h0, 32'h40, 4, 32'hDEADBEEF, 0, 0);
        run_transfer("fill_src_ignored", 1'b1, 32'h3, 32'h80, 2, 32'h1234_5678, 0, 0);
    endtask

    task automatic test_misalign();
        run_transfer("dst_misaligned", 1'b0, 32'h0, 32'h102, 3, 32'h0, 0, 0);
        run_transfer("clears_err", 1'b1, 32'h0, 32'h500, 1, 32'h5A5A_A5A5, 0, 0);
        run_transfer("src_misaligned", 1'b0, 32'h201, 32'h600, 2, 32'h0, 0, 0);
        run_transfer("fill_dst_misaligned", 1'b1, 32'h0, 32'h601, 2, 32'h1, 0, 0);
    endtask

    task automatic test_len0_and_busy_start();
        run_transfer("len0", 1'b0, 32'h0, 32'h700, 0, 32'h0, 0, 0);
        run_transfer("start_while_busy", 1'b1, 32'h0, 32'h720, 6, 32'hCAFE_F00D, 0, 2);
        run_transfer("start_while_copy", 1'b0, 32'h10, 32'h760, 3, 32'h0, 0, 3);
    endtask

    task automatic test_abort();
        run_transfer("abort_wr2", 1'b0, 32'h20, 32'h800, 5, 32'h0, 4, 0);
        run_transfer("abort_rd2", 1'b0, 32'h20, 32'h840, 5, 32'h0, 3, 0);
        run_transfer("abort_fill", 1'b1, 32'h0, 32'h880, 7, 32'h7777_0000, 3, 0);
    endtask

    task automatic test_reset_mid_and_wrap();
        @(negedge clk);
        mode_i = 1'b1; dst_i = 32'h200; len_i = 13'd8; fill_i = 32'h0BAD_F111; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (we_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill_we: got %b want 1", we_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({we_o, busy_o, done_o, err_o} !== 4'b0 || addr_o !== '0 || data_o !== '0 || count_o !== '0) begin
            errors++;
            $display("FAIL async_reset: we=%b busy=%b done=%b err=%b addr=%h data=%h count=%0d want all 0",
                     we_o, busy_o, done_o, err_o, addr_o, data_o, count_o);
        end
        @(negedge clk);
        rst = 1'b1;
        wlog_a.delete();
        wlog_d.delete();
        repeat (5) @(negedge clk);
        checks++;
        if (wlog_a.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: writes=%0d busy=%b want 0 0", wlog_a.size(), busy_o);
        end
        run_transfer("wrap_fill", 1'b1, 32'h0, 32'hFFFF_FFFC, 2, 32'h9999_1111, 0, 0);
        run_transfer("wrap_copy", 1'b0, 32'hFFFF_FFF8, 32'h0000_0900, 4, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] s, d;
        int n, ab;
        logic m;
        for (int k = 0; k < 12; k++) begin
            m = 1'($urandom_range(0, 1));
            s = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            d = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            n = $urandom_range(1, 20);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : 0;
            run_transfer($sformatf("rand%0d", k), m, s, d, n, $urandom, ab, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_copy();
        test_fill();
        test_misalign();
        test_len0_and_busy_start();
        test_abort();
        test_reset_mid_and_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
